// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache between iq and mc.
// Ports: iq fetch req/hit/instr, mc word-read req/ready/data, rob flush.
module icache #(
  parameter int IndexWidth = 8,
  parameter int TagWidth   = 30 - IndexWidth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_exception_from_rob,
  input  logic        is_empty_from_iq,
  input  logic [31:0] pc_from_iq,
  output logic        is_hit_to_iq,
  output logic [31:0] instr_to_iq,
  output logic        is_request_to_mc,
  output logic [31:0] addr_to_mc,
  input  logic        is_ready_from_mc,
  input  logic [31:0] data_from_mc
);

  localparam int Lines = 1 << IndexWidth;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS,
    DROP
  } state_e;

  state_e state_q, state_d;

  // Word addresses only; pc[1:0] never matters.
  logic [29:0] req_pc_q, req_pc_d;
  logic [29:0] pend_pc_q, pend_pc_d;
  logic        pend_v_q, pend_v_d;
  logic        hit_q, hit_d;
  logic [31:0] instr_q, instr_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [Lines-1:0] valid_q, valid_d;

  logic [TagWidth-1:0] tag_mem [Lines];
  logic [31:0]         data_mem [Lines];

  logic                  req;
  logic                  flush;
  logic                  fill_en;
  logic                  lookup_hit;
  logic [IndexWidth-1:0] req_idx;
  logic [TagWidth-1:0]   req_tag;
  logic                  unused_pc_lo;

  assign unused_pc_lo = ^pc_from_iq[1:0];

  assign req     = !is_empty_from_iq;
  assign flush   = is_exception_from_rob;
  assign req_idx = req_pc_q[IndexWidth-1:0];
  assign req_tag = req_pc_q[29:IndexWidth];

  assign lookup_hit = valid_q[req_idx] &&
                      (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    pend_pc_d = pend_pc_q;
    pend_v_d  = pend_v_q;
    hit_d     = 1'b0;
    instr_d   = instr_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    fill_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          req_pc_d = pend_pc_q;
          pend_v_d = 1'b0;
          state_d  = LOOKUP;
          // Keep a same-cycle request rather than lose it.
          if (req) begin
            pend_pc_d = pc_from_iq[31:2];
            pend_v_d  = 1'b1;
          end
        end else if (req) begin
          req_pc_d = pc_from_iq[31:2];
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          hit_d   = 1'b1;
          instr_d = data_mem[req_idx];
          state_d = IDLE;
        end else begin
          mc_req_d  = 1'b1;
          mc_addr_d = {req_pc_q, 2'b00};
          state_d   = MISS;
        end
      end
      MISS: begin
        if (is_ready_from_mc) begin
          fill_en  = 1'b1;
          mc_req_d = 1'b0;
          hit_d    = 1'b1;
          instr_d  = data_from_mc;
          state_d  = IDLE;
        end
      end
      DROP: begin
        if (is_ready_from_mc) begin
          fill_en  = 1'b1;
          mc_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase

    if (req && state_q != IDLE) begin
      pend_pc_d = pc_from_iq[31:2];
      pend_v_d  = 1'b1;
    end

    // Flush wins; an in-flight mc read is still completed and filled.
    if (flush) begin
      hit_d     = 1'b0;
      instr_d   = instr_q;
      pend_v_d  = 1'b0;
      pend_pc_d = pend_pc_q;
      mc_addr_d = mc_addr_q;
      unique case (state_q)
        IDLE, LOOKUP: begin
          state_d  = IDLE;
          req_pc_d = req_pc_q;
          mc_req_d = mc_req_q;
        end
        MISS, DROP: begin
          state_d  = is_ready_from_mc ? IDLE : DROP;
          mc_req_d = !is_ready_from_mc;
        end
      endcase
    end

    valid_d = valid_q;
    if (fill_en) valid_d[req_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_pc_q  <= '0;
      pend_pc_q <= '0;
      pend_v_q  <= 1'b0;
      hit_q     <= 1'b0;
      instr_q   <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      pend_pc_q <= pend_pc_d;
      pend_v_q  <= pend_v_d;
      hit_q     <= hit_d;
      instr_q   <= instr_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= data_from_mc;
    end
  end

  assign is_hit_to_iq     = hit_q;
  assign instr_to_iq      = instr_q;
  assign is_request_to_mc = mc_req_q;
  assign addr_to_mc       = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized fetch stream plus flush/reset scenarios,
// checked against a behavioural direct-mapped cache model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        empty = 1'b1;
  logic [31:0] pc = '0;
  logic        ready = 1'b0;
  logic [31:0] mdata = '0;
  logic        hit;
  logic [31:0] instr;
  logic        mreq;
  logic [31:0] addr;

  icache dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_exception_from_rob (flush),
    .is_empty_from_iq      (empty),
    .pc_from_iq            (pc),
    .is_hit_to_iq          (hit),
    .instr_to_iq           (instr),
    .is_request_to_mc      (mreq),
    .addr_to_mc            (addr),
    .is_ready_from_mc      (ready),
    .data_from_mc          (mdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit          mv [256];
  logic [31:0] mt [256];
  logic [31:0] md [256];
  logic [31:0] last_instr = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 10;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[idx_of(a)] && mt[idx_of(a)] == tag_of(a);
  endfunction

  task automatic m_fill(input logic [31:0] a, input logic [31:0] w);
    mv[idx_of(a)] = 1'b1;
    mt[idx_of(a)] = tag_of(a);
    md[idx_of(a)] = w;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask

  task automatic req_pulse(input logic [31:0] a);
    empty = 1'b0;
    pc = a;
    step();
    empty = 1'b1;
  endtask

  // One isolated fetch; w is the word mc returns on a miss.
  task automatic fetch(input logic [31:0] a, input int d,
                       input logic [31:0] w);
    int i;
    i = idx_of(a);
    req_pulse(a);
    step();
    if (m_hit(a)) begin
      chk("hit_pulse", hit, 1);
      chk("hit_instr", instr, md[i]);
      chk("hit_noreq", mreq, 0);
      last_instr = md[i];
    end else begin
      chk("miss_nohit", hit, 0);
      chk("miss_req", mreq, 1);
      chk("miss_addr", addr, a & 32'hFFFF_FFFC);
      for (int k = 0; k < d; k++) begin
        step();
        chk("miss_hold", mreq, 1);
        chk("miss_wait", hit, 0);
      end
      ready = 1'b1;
      mdata = w;
      step();
      ready = 1'b0;
      chk("fill_hit", hit, 1);
      chk("fill_instr", instr, w);
      chk("fill_drop", mreq, 0);
      m_fill(a, w);
      last_instr = w;
    end
    step();
    chk("pulse_end", hit, 0);
    chk("instr_hold", instr, last_instr);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wa;
    logic [31:0] wb;
    m_clear();
    #12;
    chk("rst_hit", hit, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", mreq, 0);
    chk("rst_addr", addr, 0);
    rst = 1'b1;
    step();

    // Cold miss then repeat hit.
    fetch(32'h0000_0000, 5, 32'h0000_0013);
    chk("cold_instr", instr, 32'h0000_0013);
    fetch(32'h0000_0000, 0, 32'h0);

    // Conflict on index 0.
    fetch(32'h0000_0400, 1, 32'hAAAA_0400);
    fetch(32'h0000_0000, 2, 32'hBBBB_0000);
    fetch(32'h0000_0400, 0, 32'hCCCC_0400);

    // Flush during MISS, then a request into pending.
    a = 32'h0000_2004;
    wa = 32'h1234_2004;
    req_pulse(a);
    step();
    chk("fm_req", mreq, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fm_nohit", hit, 0);
    chk("fm_reqheld", mreq, 1);
    req_pulse(32'h0000_1000);
    chk("fm_pend_req", mreq, 1);
    chk("fm_pend_addr", addr, a);
    step();
    ready = 1'b1;
    mdata = wa;
    step();
    ready = 1'b0;
    m_fill(a, wa);
    chk("fm_drop_nohit", hit, 0);
    chk("fm_drop_req", mreq, 0);
    chk("fm_instr_hold", instr, last_instr);
    step();
    chk("fm_idle_req", mreq, 0);
    step();
    chk("fm_new_req", mreq, 1);
    chk("fm_new_addr", addr, 32'h0000_1000);
    wb = 32'h5555_1000;
    ready = 1'b1;
    mdata = wb;
    step();
    ready = 1'b0;
    chk("fm_new_hit", hit, 1);
    chk("fm_new_instr", instr, wb);
    m_fill(32'h0000_1000, wb);
    last_instr = wb;
    step();
    chk("fm_pulse_end", hit, 0);
    fetch(a, 0, 32'h0);

    // Flush in LOOKUP on a would-be hit.
    req_pulse(a);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_nohit", hit, 0);
    chk("fl_noreq", mreq, 0);
    chk("fl_instr", instr, last_instr);
    step();
    chk("fl_idle_hit", hit, 0);
    fetch(32'h0000_1000, 0, 32'h0);

    // Flush coinciding with ready in MISS.
    a = 32'h0000_3008;
    req_pulse(a);
    step();
    chk("fr_req", mreq, 1);
    step();
    flush = 1'b1;
    ready = 1'b1;
    mdata = 32'h7777_3008;
    step();
    flush = 1'b0;
    ready = 1'b0;
    m_fill(a, 32'h7777_3008);
    chk("fr_nohit", hit, 0);
    chk("fr_noreq", mreq, 0);
    step();
    fetch(a, 0, 32'h0);

    // Top address wraps to last index, tag all ones.
    fetch(32'hFFFF_FFFF, 2, 32'hDEAD_BEEF);
    fetch(32'hFFFF_FFFC, 0, 32'h0);
    chk("top_idx", idx_of(32'hFFFF_FFFC), 255);

    // Randomized fetch stream over a few conflicting tags.
    for (int n = 0; n < 120; n++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) |
          $urandom_range(0, 3);
      fetch(a, $urandom_range(0, 3), $urandom);
    end

    // Reset mid-miss.
    a = 32'h0000_300C;
    if (m_hit(a)) a = 32'h0000_F00C;
    req_pulse(a);
    step();
    chk("rm_req", mreq, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_hit", hit, 0);
    chk("rm_instr", instr, 0);
    chk("rm_req0", mreq, 0);
    chk("rm_addr", addr, 0);
    #3;
    rst = 1'b1;
    m_clear();
    last_instr = '0;
    step();
    ready = 1'b1;
    mdata = 32'h9999_9999;
    step();
    ready = 1'b0;
    chk("rm_late_hit", hit, 0);
    chk("rm_late_req", mreq, 0);
    chk("rm_late_instr", instr, 0);
    fetch(32'h0000_3008, 1, 32'h4444_3008);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
